// File: rtl/pwr_en_sequencer_if.sv
// Control/status bundle for pwr_en_sequencer.
//   master modport: the controller side. It drives start, abort, target_mask and dwell_cycles,
//                   and observes pwr_en_out, busy, done, phase and active_cnt.
//   slave modport:  the sequencer side, with the opposite directions.
interface pwr_en_sequencer_if #(
  parameter int unsigned NUM_MODULES = 32,
  parameter int unsigned DWELL_W     = 32
);
  localparam int unsigned CntW = $clog2(NUM_MODULES + 1);

  logic                   start;
  logic                   abort;
  logic [NUM_MODULES-1:0] target_mask;
  logic [DWELL_W-1:0]     dwell_cycles;
  logic [NUM_MODULES-1:0] pwr_en_out;
  logic                   busy;
  logic                   done;
  logic [1:0]             phase;
  logic [CntW-1:0]        active_cnt;

  modport master (
    output start, abort, target_mask, dwell_cycles,
    input  pwr_en_out, busy, done, phase, active_cnt
  );

  modport slave (
    input  start, abort, target_mask, dwell_cycles,
    output pwr_en_out, busy, done, phase, active_cnt
  );
endinterface

// File: rtl/pwr_en_sequencer.sv
// Staggered power-enable sequencer. On start it latches a lane mask and a dwell time. It then
// enables the latched lanes one at a time, lowest index first, with GAP cycles between steps.
// It holds the full mask for dwell_cycles+1 cycles, then disables the lanes one at a time,
// highest index first, and pulses done. A graceful abort skips straight to the ramp-down.
//   clk100m : clock, rising edge
//   rstn    : synchronous active-low reset
//   bus     : slave side of pwr_en_sequencer_if
//             inputs : start, abort, target_mask, dwell_cycles
//             outputs: pwr_en_out, busy, done, phase, active_cnt
module pwr_en_sequencer #(
  parameter int unsigned NUM_MODULES = 32,
  parameter int unsigned GAP         = 16,
  parameter int unsigned DWELL_W     = 32
) (
  input logic              clk100m,
  input logic              rstn,
  pwr_en_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(NUM_MODULES + 1);
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapReload = GapW'(GAP - 1);

  // Encoding matches the phase output directly.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StDwell    = 2'd2,
    StRampDown = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MODULES-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [NUM_MODULES-1:0] pwr_en_q, pwr_en_d;
  logic [CntW-1:0]        active_cnt_q, active_cnt_d;
  logic                   done_q, done_d;

  logic [NUM_MODULES-1:0] pending;
  logic [NUM_MODULES-1:0] up_bit;
  logic [NUM_MODULES-1:0] down_bit;
  logic                   last_up;
  logic                   last_down;

  // Step selection: lowest pending lane on the way up, highest enabled lane on the way down.
  always_comb begin
    pending  = mask_q & ~pwr_en_q;
    up_bit   = '0;
    down_bit = '0;
    for (int i = NUM_MODULES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        up_bit    = '0;
        up_bit[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MODULES; i++) begin
      if (pwr_en_q[i]) begin
        down_bit    = '0;
        down_bit[i] = 1'b1;
      end
    end
    last_up   = ((pending & ~up_bit) == '0);
    last_down = ((pwr_en_q & ~down_bit) == '0);
  end

  // State register.
  always_ff @(posedge clk100m) begin
    if (!rstn) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      pwr_en_q     <= '0;
      active_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pwr_en_q     <= pwr_en_d;
      active_cnt_q <= active_cnt_d;
      done_q       <= done_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pwr_en_d     = pwr_en_q;
    active_cnt_d = active_cnt_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start wins over abort here; abort has no meaning while idle.
        if (bus.start) begin
          mask_d    = bus.target_mask;
          dwell_d   = bus.dwell_cycles;
          gap_cnt_d = GapReload;
          state_d   = StRampUp;
        end
      end

      StRampUp: begin
        if (bus.abort) begin
          // Lanes already on stay on and are stepped down normally.
          gap_cnt_d = GapReload;
          state_d   = StRampDown;
        end else if (pending == '0) begin
          dwell_cnt_d = dwell_q;
          state_d     = StDwell;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end else begin
          pwr_en_d     = pwr_en_q | up_bit;
          active_cnt_d = active_cnt_q + CntW'(1);
          gap_cnt_d    = GapReload;
          if (last_up) begin
            dwell_cnt_d = dwell_q;
            state_d     = StDwell;
          end
        end
      end

      StDwell: begin
        if (bus.abort || (dwell_cnt_q == '0)) begin
          gap_cnt_d = GapReload;
          state_d   = StRampDown;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end

      StRampDown: begin
        if (pwr_en_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end else begin
          pwr_en_d     = pwr_en_q & ~down_bit;
          active_cnt_d = active_cnt_q - CntW'(1);
          gap_cnt_d    = GapReload;
          if (last_down) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.pwr_en_out = pwr_en_q;
    bus.busy       = (state_q != StIdle);
    bus.done       = done_q;
    bus.phase      = state_q;
    bus.active_cnt = active_cnt_q;
  end
endmodule

// File: doc/pwr_en_sequencer.md
PWR_EN_SEQUENCER -- requirements
Module: pwr_en_sequencer

Interface
REQ-001 SHALL have parameter NUM_MODULES, default 32, giving the number of power-enable lanes.
REQ-002 SHALL have parameter GAP, default 16, giving the cycles between successive lane enable/disable steps; legal range >= 1.
REQ-003 SHALL have parameter DWELL_W, default 32, giving the width of the dwell counter.
REQ-004 SHALL have port clk100m, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled every edge.
REQ-007 SHALL have port abort, input, 1 bit: graceful-stop request.
REQ-008 SHALL have port target_mask, input, NUM_MODULES bits: lanes to enable, latched when start is accepted.
REQ-009 SHALL have port dwell_cycles, input, DWELL_W bits: hold time at full mask, latched when start is accepted.
REQ-010 SHALL have port pwr_en_out, output, NUM_MODULES bits: registered per-lane enables driving the load array's pwr_en_in.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port phase, output, 2 bits: 0 IDLE, 1 RAMP_UP, 2 DWELL, 3 RAMP_DOWN.
REQ-014 SHALL have port active_cnt, output, $clog2(NUM_MODULES+1) bits: popcount of pwr_en_out, valid in the same cycle as pwr_en_out.

Function
REQ-015 SHALL implement FSM states IDLE, RAMP_UP, DWELL, RAMP_DOWN.
REQ-016 In IDLE with start=1: SHALL latch target_mask and dwell_cycles, enter RAMP_UP, and load gap_cnt=GAP-1.
REQ-017 In RAMP_UP, each edge: if gap_cnt != 0, SHALL decrement gap_cnt; else SHALL set the lowest-index latched bit not yet enabled and reload gap_cnt=GAP-1.
REQ-018 First enable SHALL occur GAP edges after the accepting edge, and each subsequent enable GAP edges after the previous one; at most one lane changes per edge.
REQ-019 On the edge that sets the last pending bit, SHALL enter DWELL and load dwell_cnt=latched dwell_cycles.
REQ-020 In RAMP_UP with no pending bits (mask=0), SHALL enter DWELL on the next edge.
REQ-021 In DWELL, each edge: if dwell_cnt != 0, SHALL decrement; else SHALL enter RAMP_DOWN with gap_cnt=GAP-1, so DWELL lasts dwell_cycles+1 cycles.
REQ-022 In RAMP_DOWN, SHALL use the same gap timing as RAMP_UP, clearing the highest-index set bit per step.
REQ-023 On the edge that clears the last set bit, SHALL enter IDLE and assert done for exactly the following cycle.
REQ-024 In RAMP_DOWN with pwr_en_out=0 on entry, SHALL enter IDLE on the next edge and pulse done.
REQ-025 abort=1 in RAMP_UP or DWELL SHALL force RAMP_DOWN on that edge with gap_cnt=GAP-1; enabled lanes are retained until stepped down.
REQ-026 abort SHALL be ignored in IDLE and RAMP_DOWN.
REQ-027 start SHALL be ignored outside IDLE; when start and abort are both high in IDLE, start is accepted and abort is ignored.
REQ-028 Changes on target_mask or dwell_cycles after acceptance SHALL have no effect on the current run.
REQ-029 active_cnt SHALL increment or decrement on the same edge as the corresponding lane change and SHALL never exceed NUM_MODULES.

Reset
REQ-030 When rstn=0 at an edge, SHALL set state=IDLE, pwr_en_out=0, active_cnt=0, busy=0, done=0, phase=0, and clear all counters and latches.
REQ-031 Reset mid-run SHALL drop all lanes on that edge, with no done pulse.

Verification
REQ-032 GAP=4, mask=0x0000000F, dwell=10, start at edge 0 -> bits 0..3 set at edges 4/8/12/16; DWELL edges 16-27; bits 3..0 cleared at edges 31/35/39/43; done=1 for the cycle after edge 43 only; busy=0 from edge 43.
REQ-033 GAP=4, mask=0, dwell=0, start at edge 0 -> phase 1->2->3->0 at edges 0/1/2/3; pwr_en_out stays 0; done pulses after edge 3.
REQ-034 GAP=4, mask=0xFF, abort at edge 9 -> bits 0,1 set at edges 4/8; RAMP_DOWN at edge 9; bit1 cleared at edge 13, bit0 at edge 17; done pulses; bits 2..7 never set.
REQ-035 GAP=1, mask=0x80000001 -> bit0 set, then bit31 on the next edge; after dwell, bit31 cleared before bit0; active_cnt sequence 1,2,...,1,0.
REQ-036 Second start pulse and target_mask change during DWELL -> ignored; run completes with the original mask; a single done pulse.
REQ-037 rstn=0 for one edge mid-DWELL with mask=0xFFFFFFFF -> pwr_en_out=0, active_cnt=0, busy=0 at that edge; no done pulse; next start runs normally.
